// File: rtl/cpu_reg_file_pkg.sv
// Shared types and constants for the CPU byte-register file.
package cpu_reg_pkg;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_LOAD = 2'b01,
    OP_INC  = 2'b10,
    OP_DEC  = 2'b11
  } op_e;

  localparam int         DEF_WIDTH    = 8;
  localparam logic [7:0] SP_RESET_VAL = 8'hFD;

endpackage

// File: rtl/cpu_reg_file_reg_cell.sv
// One register of the file: load/inc/dec datapath plus sync active-low reset.
module reg_cell
  import cpu_reg_pkg::*;
#(
  parameter int               WIDTH   = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] d_next,
  output logic             wrap
);

  // d_next/wrap are computed regardless of en so the top can forward and flag them.
  always_comb begin
    d_next = q;
    wrap   = 1'b0;
    case (op_e'(op))
      OP_LOAD: d_next = wr_data;
      OP_INC: begin
        d_next = q + 1'b1;
        wrap   = (q == {WIDTH{1'b1}});
      end
      OP_DEC: begin
        d_next = q - 1'b1;
        wrap   = (q == '0);
      end
      default: d_next = q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d_next;
    end
  end

endmodule

// File: rtl/cpu_reg_file.sv
// Parametrised CPU byte-register file: one load/inc/dec write port, two read ports, registered flags.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module cpu_reg_file
  import cpu_reg_pkg::*;
#(
  parameter int               WIDTH    = DEF_WIDTH,
  parameter int               NUM_REGS = 4,
  parameter int               SP_INDEX = 3,
  parameter logic [WIDTH-1:0] SP_RESET = WIDTH'(SP_RESET_VAL),
  localparam int              SELW     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       op,
  input  logic [SELW-1:0]  wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [SELW-1:0]  rd_sel_a,
  input  logic [SELW-1:0]  rd_sel_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             flag_vld,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_w,
  output logic             sel_err
);

  // flag_vld and sel_err are single-cycle pulses with no back-pressure: the consumer
  // must sample them in the cycle after the op; flag_z/n/w stay valid until the next legal op.

  logic             active;
  logic             legal;
  logic             wr_ok;
  logic [WIDTH-1:0] q_arr    [NUM_REGS];
  logic [WIDTH-1:0] nxt_arr  [NUM_REGS];
  logic             wrap_arr [NUM_REGS];
  logic [WIDTH-1:0] res;
  logic             res_wrap;

  assign active = (op_e'(op) != OP_HOLD);
  // One extra bit so NUM_REGS itself fits when it is a power of two.
  assign legal  = ({1'b0, wr_sel} < (SELW + 1)'(NUM_REGS));
  assign wr_ok  = active && legal;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
    reg_cell #(
      .WIDTH  (WIDTH),
      .RST_VAL((i == SP_INDEX) ? SP_RESET : {WIDTH{1'b0}})
    ) u_cell (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (wr_ok && (wr_sel == SELW'(i))),
      .op     (op),
      .wr_data(wr_data),
      .q      (q_arr[i]),
      .d_next (nxt_arr[i]),
      .wrap   (wrap_arr[i])
    );
  end

  always_comb begin
    res      = '0;
    res_wrap = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_sel == SELW'(i)) begin
        res      = nxt_arr[i];
        res_wrap = wrap_arr[i];
      end
    end
  end

  // Out-of-range selects fall through to zero.
  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_sel_a == SELW'(i)) rd_data_a = q_arr[i];
      if (rd_sel_b == SELW'(i)) rd_data_b = q_arr[i];
    end
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && (rd_sel_a == wr_sel)) rd_data_a = res;
    if (wr_ok && (rd_sel_b == wr_sel)) rd_data_b = res;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flag_vld <= 1'b0;
      flag_z   <= 1'b0;
      flag_n   <= 1'b0;
      flag_w   <= 1'b0;
      sel_err  <= 1'b0;
    end else begin
      flag_vld <= wr_ok;
      sel_err  <= active && !legal;
      if (wr_ok) begin
        flag_z <= (res == '0);
        flag_n <= res[WIDTH-1];
        flag_w <= res_wrap;
      end
    end
  end

endmodule
